// File: rtl/network_run_sequencer_pkg.sv
// Configuration packages for the network run sequencer: network geometry,
// stream flag layout, and the sequencer's own command/state types.
package network_config;
  localparam int NUM_INP      = 4;
  localparam int CHARGE_WIDTH = 8;
endpackage

package stream_config;
  localparam int NUM_FLG = 4;
  localparam int SNC     = 0;
  localparam int CLR     = 1;
endpackage

package run_seq_config;
  import network_config::*;
  import stream_config::*;

  typedef enum logic [1:0] {OP_NOP, OP_SPK, OP_RUN, OP_CLR} cmd_op_t;
  typedef enum logic [1:0] {IDLE, EMIT, RUN, DONE} state_t;

  localparam int INP_WIDTH = NUM_INP * CHARGE_WIDTH;
endpackage

// File: rtl/network_run_sequencer_packer.sv
// Combinational packet assembly: flag prefix in the MSBs, input charges below.
module run_seq_packer
  import network_config::*, stream_config::*, run_seq_config::*;
#(
  parameter int PKT_WIDTH = NUM_FLG + INP_WIDTH
) (
  input  logic                 snc,
  input  logic                 clr,
  input  logic [INP_WIDTH-1:0] inp,
  output logic [PKT_WIDTH-1:0] pkt
);

  always_comb begin
    pkt = '0;
    pkt[PKT_WIDTH-NUM_FLG-1 -: INP_WIDTH] = inp;
    pkt[PKT_WIDTH-1-SNC] = snc;
    pkt[PKT_WIDTH-1-CLR] = clr;
  end

endmodule

// File: rtl/network_run_sequencer.sv
// Expands host commands (NOP/SPK/RUN/CLR) into network packets with SNC on the
// last packet. Define NETWORK_RUN_SEQUENCER_STATS_EN to enable the pkt_count counter.
module network_run_sequencer
  import network_config::*, stream_config::*, run_seq_config::*;
#(
  parameter int PKT_WIDTH = NUM_FLG + NUM_INP*CHARGE_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_WIDTH-1:0] cmd_cnt,
  input  logic                 cmd_sync,
  input  logic [INP_WIDTH-1:0] cmd_inp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PKT_WIDTH-1:0] out_pkt,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pkt_count
);

  state_t                 state_p0, state_p1;
  logic [CNT_WIDTH-1:0]   cnt_p0, cnt_p1;
  logic                   sync_p0, sync_p1;
  logic                   vld_p0, vld_p1;
  logic                   done_p1;
  logic [PKT_WIDTH-1:0]   pkt_p0, pkt_p1;
  logic                   pack_snc, pack_clr;
  logic [INP_WIDTH-1:0]   pack_inp;
  logic [PKT_WIDTH-1:0]   pack_pkt;

  // Contents of the next packet: the accepted command in IDLE, else the next idle step.
  always_comb begin
    pack_snc = 1'b0;
    pack_clr = 1'b0;
    pack_inp = '0;
    if (state_p1 == IDLE) begin
      pack_snc = cmd_sync && ((cmd_op_t'(cmd_op) != OP_RUN) || (cmd_cnt == CNT_WIDTH'(1)));
      pack_clr = (cmd_op_t'(cmd_op) == OP_CLR);
      if (cmd_op_t'(cmd_op) == OP_SPK) pack_inp = cmd_inp;
    end else begin
      pack_snc = sync_p1 && (cnt_p1 == CNT_WIDTH'(2));
    end
  end

  run_seq_packer #(.PKT_WIDTH(PKT_WIDTH)) u_packer (
    .snc (pack_snc),
    .clr (pack_clr),
    .inp (pack_inp),
    .pkt (pack_pkt)
  );

  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = cnt_p1;
    sync_p0  = sync_p1;
    vld_p0   = vld_p1;
    pkt_p0   = pkt_p1;
    case (state_p1)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_t'(cmd_op))
            OP_NOP: state_p0 = DONE;
            OP_SPK, OP_CLR: begin
              state_p0 = EMIT;
              vld_p0   = 1'b1;
              pkt_p0   = pack_pkt;
            end
            OP_RUN: begin
              if (cmd_cnt == '0) begin
                state_p0 = DONE;
              end else begin
                state_p0 = RUN;
                cnt_p0   = cmd_cnt;
                sync_p0  = cmd_sync;
                vld_p0   = 1'b1;
                pkt_p0   = pack_pkt;
              end
            end
            default: state_p0 = DONE;
          endcase
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_p0 = DONE;
          vld_p0   = 1'b0;
        end
      end
      RUN: begin
        // Next step is presented back-to-back; no bubble between packets.
        if (out_ready) begin
          cnt_p0 = cnt_p1 - CNT_WIDTH'(1);
          if (cnt_p1 == CNT_WIDTH'(1)) begin
            state_p0 = DONE;
            vld_p0   = 1'b0;
          end else begin
            pkt_p0 = pack_pkt;
          end
        end
      end
      DONE:    state_p0 = IDLE;
      default: state_p0 = IDLE;
    endcase
  end

  // Registered stage: all outputs come from here.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      sync_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      pkt_p1   <= '0;
      done_p1  <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      cnt_p1   <= cnt_p0;
      sync_p1  <= sync_p0;
      vld_p1   <= vld_p0;
      pkt_p1   <= pkt_p0;
      done_p1  <= (state_p0 == DONE);
    end
  end

  assign cmd_ready = (state_p1 == IDLE);
  assign busy      = (state_p1 != IDLE);
  assign out_valid = vld_p1;
  assign out_pkt   = pkt_p1;
  assign done      = done_p1;

`ifdef NETWORK_RUN_SEQUENCER_STATS_EN
  logic [31:0] stat_cnt_p1;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      stat_cnt_p1 <= '0;
    end else if (vld_p1 && out_ready && (stat_cnt_p1 != '1)) begin
      stat_cnt_p1 <= stat_cnt_p1 + 32'd1;
    end
  end

  assign pkt_count = stat_cnt_p1;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_network_run_sequencer.sv
// Self-checking bench for network_run_sequencer: table vectors, hand-written
// stall/reset sequences and randomized commands against a packet-list model.
module tb_network_run_sequencer;
  import network_config::*;
  import stream_config::*;

  localparam int CW    = 6;
  localparam int INP_W = NUM_INP * CHARGE_WIDTH;
  localparam int PKT_W = NUM_FLG + INP_W;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef struct {
    logic [1:0]       op;
    logic [CW-1:0]    cnt;
    logic             sync;
    logic [INP_W-1:0] inp;
    int               stall;
    int               exp_n;
    pkt_t             exp_last;
  } vec_t;

  logic             clk;
  logic             arstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CW-1:0]    cmd_cnt;
  logic             cmd_sync;
  logic [INP_W-1:0] cmd_inp;
  logic             out_valid;
  logic             out_ready;
  pkt_t             out_pkt;
  logic             busy;
  logic             done;
  logic [31:0]      pkt_count;

  network_run_sequencer #(.PKT_WIDTH(PKT_W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_sync  (cmd_sync),
    .cmd_inp   (cmd_inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .busy      (busy),
    .done      (done),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   exp_stat = 0;
  pkt_t got_q[$];
  pkt_t exp_q[$];
  vec_t tbl[8];

  always @(posedge clk) begin
    if (arstn && out_valid && out_ready) got_q.push_back(out_pkt);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input bit snc, input bit clr, input logic [INP_W-1:0] inp);
    pkt_t p;
    p = '0;
    p[PKT_W-1-SNC] = snc;
    p[PKT_W-1-CLR] = clr;
    for (int i = 0; i < NUM_INP; i++)
      p[PKT_W-NUM_FLG-i*CHARGE_WIDTH-1 -: CHARGE_WIDTH] = inp[INP_W-1-i*CHARGE_WIDTH -: CHARGE_WIDTH];
    return p;
  endfunction

  task automatic build_model(input logic [1:0] op, input int cnt, input bit sync,
                             input logic [INP_W-1:0] inp);
    exp_q.delete();
    case (op)
      2'd1: exp_q.push_back(mk(sync, 1'b0, inp));
      2'd2: for (int k = cnt; k >= 1; k--) exp_q.push_back(mk(sync && (k == 1), 1'b0, '0));
      2'd3: exp_q.push_back(mk(sync, 1'b1, '0));
      default: ;
    endcase
  endtask

  function automatic logic rdy(input int stall);
    if (stall == 0) return 1'b1;
    return ($urandom_range(0, 99) >= stall);
  endfunction

  task automatic chk_stat();
`ifdef NETWORK_RUN_SEQUENCER_STATS_EN
    chk("stat_count", pkt_count, exp_stat);
`else
    chk("stat_zero", pkt_count, 0);
`endif
  endtask

  task automatic do_reset();
    arstn = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pkt", out_pkt, 0);
    exp_stat = 0;
    chk_stat();
    arstn = 1'b1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input logic sync,
                         input logic [INP_W-1:0] inp, input int stall, input int exp_n,
                         input pkt_t exp_last);
    int   base, cyc;
    bit   saw_done, hs_before, stall_before;
    pkt_t held;
    build_model(op, int'(cnt), sync, inp);
    base = got_q.size();
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_sync = sync; cmd_inp = inp;
    out_ready = rdy(stall);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_cnt = CW'($urandom); cmd_sync = 1'($urandom); cmd_inp = $urandom;
    chk("accept_ready_low", cmd_ready, 0);
    chk("accept_busy", busy, 1);
    if (exp_q.size() > 0) chk("first_valid_latency", out_valid, 1);
    else                  chk("empty_done_latency", done, 1);
    saw_done = done;
    cyc = 0;
    while (!saw_done && cyc < 2000) begin
      out_ready    = rdy(stall);
      hs_before    = out_valid && out_ready;
      stall_before = out_valid && !out_ready;
      held         = out_pkt;
      @(posedge clk); #1;
      cyc++;
      if (stall_before) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_pkt_hold", out_pkt, held);
      end
      if (done) begin
        saw_done = 1'b1;
        chk("done_after_last_hs", hs_before, 1);
      end
    end
    chk("done_seen", saw_done, 1);
    chk("valid_low_at_done", out_valid, 0);
    chk("npkt_model", got_q.size() - base, exp_q.size());
    if (exp_n >= 0) chk("npkt_table", got_q.size() - base, exp_n);
    for (int i = 0; i < exp_q.size() && (base + i) < got_q.size(); i++)
      chk("pkt_value", got_q[base+i], exp_q[i]);
    if (exp_n > 0 && got_q.size() > base) chk("last_pkt_table", got_q[got_q.size()-1], exp_last);
    exp_stat += exp_q.size();
    chk_stat();
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int base;
    pkt_t held;
    cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_sync = 1'b0; cmd_inp = '0;
    out_ready = 1'b0; arstn = 1'b0;
    do_reset();

    tbl[0] = '{2'd1, 6'd0, 1'b1, 32'h0300_0000, 0,  1, 36'h8_0300_0000};
    tbl[1] = '{2'd2, 6'd4, 1'b1, 32'hFFFF_FFFF, 0,  4, 36'h8_0000_0000};
    tbl[2] = '{2'd2, 6'd0, 1'b1, 32'h1234_5678, 0,  0, 36'h0};
    tbl[3] = '{2'd0, 6'd9, 1'b1, 32'h1234_5678, 0,  0, 36'h0};
    tbl[4] = '{2'd3, 6'd0, 1'b0, 32'hDEAD_BEEF, 0,  1, 36'h4_0000_0000};
    tbl[5] = '{2'd2, 6'd1, 1'b1, 32'h0,         0,  1, 36'h8_0000_0000};
    tbl[6] = '{2'd1, 6'd3, 1'b0, 32'hA5FF_0180, 40, 1, 36'h0_A5FF_0180};
    tbl[7] = '{2'd2, 6'd7, 1'b0, 32'h5555_5555, 50, 7, 36'h0};
    for (int i = 0; i < 8; i++)
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].sync, tbl[i].inp, tbl[i].stall, tbl[i].exp_n, tbl[i].exp_last);

    // RUN 3 with a five-cycle stall on packet 2
    base = got_q.size();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_cnt = 6'd3; cmd_sync = 1'b1; cmd_inp = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("stall_first_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    held = out_pkt;
    chk("stall_pkt2_value", held, mk(1'b0, 1'b0, '0));
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall5_valid", out_valid, 1);
      chk("stall5_pkt", out_pkt, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_pkt3_value", out_pkt, mk(1'b1, 1'b0, '0));
    @(posedge clk); #1;
    chk("stall_done", done, 1);
    chk("stall_handshakes", got_q.size() - base, 3);
    exp_stat += 3;
    chk_stat();
    @(posedge clk); #1;

    // reset in the middle of RUN 5, after two packets
    base = got_q.size();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_cnt = 6'd5; cmd_sync = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    arstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_npkt", got_q.size() - base, 2);
    arstn = 1'b1;
    exp_stat = 0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_quiet", out_valid, 0);
    end
    chk("midrst_npkt_after", got_q.size() - base, 2);
    chk_stat();

    // full-scale count: 2^CW-1 packets, no wrap
    run_cmd(2'd2, 6'd63, 1'b1, '0, 20, 63, 36'h8_0000_0000);

    for (int n = 0; n < 40; n++)
      run_cmd(2'($urandom_range(0, 3)), CW'($urandom_range(0, 12)), 1'($urandom),
              $urandom, 30 * $urandom_range(0, 2), -1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_run_sequencer.md
Name: network_run_sequencer

Overview:
- Command-level scheduler that sits upstream of the network packet source and produces its packet stream.
- Host-side commands arrive one per handshake. Each is expanded into one or more network packets:
  - apply spikes for one step,
  - run N idle steps,
  - clear the network.
- Sets the SNC flag on the final packet of a command on request, so output collection stays aligned to host commands.
- Replaces ad-hoc host generation of long idle runs: one RUN command covers up to 2^CNT_WIDTH-1 steps.

Parameters:
- PKT_WIDTH, default NUM_FLG + NUM_INP*CHARGE_WIDTH: width of the emitted packet.
- CNT_WIDTH, default 16: width of the RUN step counter.

Ports:
- clk  in  1  system clock.
- arstn  in  1  reset: synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  opcode: 0 NOP, 1 SPK, 2 RUN, 3 CLR.
- cmd_cnt  in  CNT_WIDTH  RUN step count.
- cmd_sync  in  1  set SNC on the last packet of this command.
- cmd_inp  in  NUM_INP*CHARGE_WIDTH  SPK charges; input 0 in the MSBs.
- out_valid  out  1  packet valid toward the packet source.
- out_ready  in  1  packet source ready.
- out_pkt  out  PKT_WIDTH  packet layout:
  - flag f at bit PKT_WIDTH-1-f;
  - input i at bits [PKT_WIDTH-NUM_FLG-i*CHARGE_WIDTH-1 -: CHARGE_WIDTH].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (arstn low at a clk edge):
  - state IDLE; counter 0;
  - out_valid=0, out_pkt=0, done=0, busy=0;
  - any command in progress is abandoned mid-operation; no partial packet is held.
- States: IDLE, EMIT (one packet pending), RUN (counted packets pending), DONE (one cycle).
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready.
- Outputs are registered.
  - out_valid rises the cycle after acceptance: 1-cycle latency.
  - out_pkt and out_valid hold stable while out_valid && !out_ready; there is no combinational path from out_ready to out_pkt.
- NUM_INP and CHARGE_WIDTH come from network_config; NUM_FLG, SNC and CLR from stream_config.
- IDLE transitions on acceptance:
  - NOP -> DONE.
  - SPK -> EMIT; out_pkt = {flags, cmd_inp}; SNC flag = cmd_sync; CLR=0.
  - CLR -> EMIT; CLR flag=1; SNC = cmd_sync; inputs all zero.
  - RUN, cmd_cnt==0 -> DONE; no packet emitted.
  - RUN, cmd_cnt>0 -> RUN; counter = cmd_cnt; inputs zero; SNC = cmd_sync && cmd_cnt==1.
- EMIT: on out_ready -> DONE, out_valid=0.
- RUN: on each out_valid && out_ready the counter decrements.
  - If the new value is 0 -> DONE, out_valid=0.
  - Otherwise the next packet is presented in the following cycle with no bubble; out_valid stays 1.
  - SNC is set only on the packet issued when the counter equals 1.
- DONE: done=1 for exactly one cycle -> IDLE.
  - Minimum command-to-command spacing is 3 cycles: accept, emit, done.
- Unused flag bits (neither SNC nor CLR) are always 0.
- The counter never wraps: the maximum cmd_cnt of 2^CNT_WIDTH-1 emits exactly that many packets.
- cmd_* inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: NETWORK_RUN_SEQUENCER_STATS_EN.
- Defined:
  - Adds a 32-bit register behind output port pkt_count. It counts every out handshake and saturates at 2^32-1.
  - Cleared by reset only.
  - Updated in the cycle after the handshake.
- Undefined:
  - pkt_count is driven constant 0 and no counter logic is synthesized.
  - All other behaviour is identical.

Decomposition:
- Package run_seq_config, importing network_config and stream_config, holds:
  - typedef enum logic [1:0] cmd_op_t {OP_NOP, OP_SPK, OP_RUN, OP_CLR};
  - typedef enum state_t {IDLE, EMIT, RUN, DONE};
  - localparam INP_WIDTH = NUM_INP*CHARGE_WIDTH.
- One combinational sub-module, run_seq_packer:
  - inputs: snc, clr, inp vector;
  - output: packet with flags placed at PKT_WIDTH-1-SNC and PKT_WIDTH-1-CLR, and inputs below the prefix.
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-RUN: issue RUN cnt=5, assert arstn=0 after 2 packets -> next cycle out_valid=0, busy=0, cmd_ready=1; no further packets.
- SPK, cmd_inp = input0 = 3, others 0, cmd_sync=1, out_ready=1:
  - exactly one packet, one cycle after acceptance;
  - SNC bit set, CLR clear, input0 field = 3;
  - done pulses the following cycle.
- RUN cnt=4, cmd_sync=1, out_ready=1:
  - 4 back-to-back packets, all inputs 0;
  - SNC only on the 4th;
  - done one cycle after the 4th handshake.
- RUN cnt=3 with out_ready low for 5 cycles during packet 2:
  - out_pkt stable throughout the stall;
  - exactly 3 handshakes total; no duplicate or lost packet.
- RUN cnt=0 and NOP: no out_valid at any time; done pulses 1 cycle after acceptance.
- CLR, cmd_sync=0: one packet with only the CLR flag set and zero inputs. With NETWORK_RUN_SEQUENCER_STATS_EN defined, pkt_count increments by 1.
